// File: rtl/instr_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_mem_responder
// Purpose  : Instruction memory with a valid/ready fetch port, fixed response
//            latency, branch flush and a program-load write port.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] ReqAddr,
    input  logic        Flush,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspInstr,
    output logic [31:0] RspAddr,
    output logic        RspErr,
    input  logic        WrEn,
    input  logic [31:0] WrAddr,
    input  logic [31:0] WrData
);

    localparam int c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW       = 3;
    localparam int c_CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nx;
    logic              w_accept;
    logic              w_enter_resp;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rsp_addr;
    logic [31:0]       r_rsp_instr;
    logic              r_rsp_err;

    logic              w_wr_ok;
    logic [c_AW-1:0]   w_wr_idx;
    logic [31:0]       w_fetch_addr;
    logic [c_AW-1:0]   w_rd_idx;
    logic              w_rd_err;
    logic [31:0]       w_rd_data;

    // Program-load port: only aligned, in-range words are written.
    assign w_wr_ok  = WrEn && (WrAddr[1:0] == 2'b00)
                      && ({2'b00, WrAddr[31:2]} < 32'(DEPTH));
    assign w_wr_idx = WrAddr[c_AW+1:2];

    // With LATENCY = 1 the read happens on the accept edge, before the
    // address register has been loaded, so read straight from the request.
    assign w_fetch_addr = (r_state == IDLE) ? ReqAddr : r_rsp_addr;
    assign w_rd_idx     = w_fetch_addr[c_AW+1:2];
    assign w_rd_err     = (w_fetch_addr[1:0] != 2'b00)
                          || ({2'b00, w_fetch_addr[31:2]} >= 32'(DEPTH));
    assign w_rd_data    = w_rd_err ? 32'h0 : r_mem[w_rd_idx];

    // Memory has no reset so program contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= WrData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        ReqReady     = 1'b0;
        RspValid     = 1'b0;
        case (r_state)
            IDLE: begin
                ReqReady = !Flush;
                if (ReqValid && !Flush) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nx   = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = c_CW'(c_CNT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (Flush) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nx   = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            RESP: begin
                RspValid = 1'b1;
                // A flush discards the response even if it is being consumed.
                if (Flush || RspReady) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Response registers; the memory read sees contents before a same-edge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_addr  <= '0;
            r_rsp_instr <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_addr <= ReqAddr;
            end
            if (w_enter_resp) begin
                r_rsp_instr <= w_rd_data;
                r_rsp_err   <= w_rd_err;
            end
        end
    end

    assign RspInstr = r_rsp_instr;
    assign RspAddr  = r_rsp_addr;
    assign RspErr   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_responder
// Purpose  : Directed and randomized fetch traffic against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [31:0] ReqAddr = '0;
    logic        Flush = 1'b0;
    logic        RspValid;
    logic        RspReady = 1'b0;
    logic [31:0] RspInstr;
    logic [31:0] RspAddr;
    logic        RspErr;
    logic        WrEn = 1'b0;
    logic [31:0] WrAddr = '0;
    logic [31:0] WrData = '0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_mem [DEPTH];

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
        .Flush(Flush),
        .RspValid(RspValid), .RspReady(RspReady), .RspInstr(RspInstr),
        .RspAddr(RspAddr), .RspErr(RspErr),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        @(negedge clk);
        WrEn = 1'b0;
        if (!bad_addr(a)) model_mem[a / 4] = d;
    endtask

    // mode 0: normal, 1: flush while waiting, 2: flush while responding
    task automatic fetch(input logic [31:0] addr, input int bp, input int mode);
        int          lat;
        bit          seen;
        logic [31:0] e_instr;
        logic        e_err;
        logic [31:0] wa;
        e_err   = bad_addr(addr);
        e_instr = e_err ? 32'h0 : model_mem[addr / 4];
        ReqValid = 1'b1; ReqAddr = addr;
        #1 check("req_ready_idle", 32'(ReqReady), 32'd1);
        @(negedge clk);
        ReqValid = 1'b0; ReqAddr = $urandom;
        lat = 1;
        if (mode == 1 && LATENCY > 1) begin
            check("wait_valid_low", 32'(RspValid), 32'd0);
            Flush = 1'b1;
            @(negedge clk);
            Flush = 1'b0;
            seen = 1'b0;
            repeat (LATENCY + 4) begin
                if (RspValid) seen = 1'b1;
                @(negedge clk);
            end
            check("flush_wait_no_rsp", 32'(seen), 32'd0);
            check("flush_wait_ready", 32'(ReqReady), 32'd1);
            return;
        end
        while (!RspValid && lat < LATENCY + 8) begin
            check("busy_ready_low", 32'(ReqReady), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("rsp_instr", RspInstr, e_instr);
        check("rsp_addr", RspAddr, addr);
        check("rsp_err", 32'(RspErr), 32'(e_err));
        check("resp_ready_low", 32'(ReqReady), 32'd0);
        if (mode == 2) begin
            Flush = 1'b1; RspReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("flush_resp_valid", 32'(RspValid), 32'd0);
            Flush = 1'b0; RspReady = 1'b0;
            #1 check("flush_resp_ready", 32'(ReqReady), 32'd1);
            return;
        end
        // Backpressure, with writes racing the held response.
        repeat (bp) begin
            wa = 32'($urandom_range(0, DEPTH - 1)) * 4;
            write_word(wa, $urandom);
            check("bp_valid", 32'(RspValid), 32'd1);
            check("bp_instr", RspInstr, e_instr);
            check("bp_addr", RspAddr, addr);
            check("bp_err", 32'(RspErr), 32'(e_err));
        end
        RspReady = 1'b1;
        @(negedge clk);
        RspReady = 1'b0;
        check("done_valid", 32'(RspValid), 32'd0);
        check("done_ready", 32'(ReqReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int r;
        logic [31:0] a;
        #1;
        check("rst_valid", 32'(RspValid), 32'd0);
        check("rst_instr", RspInstr, 32'd0);
        check("rst_addr", RspAddr, 32'd0);
        check("rst_err", 32'(RspErr), 32'd0);
        check("rst_ready", 32'(ReqReady), 32'd1);
        #22 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) write_word(32'(i) * 4, $urandom);
        write_word(32'h4, 32'hDEADBEEF);

        fetch(32'h4, 0, 0);
        fetch(32'h4, 5, 0);
        fetch(32'h6, 0, 0);
        fetch(32'h100, 0, 0);

        // Illegal writes must not alias onto real words.
        write_word(32'h100, 32'hBAD0BAD0);
        write_word(32'h6, 32'hBAD1BAD1);
        fetch(32'h0, 0, 0);
        fetch(32'h4, 1, 0);

        // Flush while idle blocks acceptance.
        Flush = 1'b1; ReqValid = 1'b1; ReqAddr = 32'h8;
        #1 check("flush_idle_ready", 32'(ReqReady), 32'd0);
        @(negedge clk);
        Flush = 1'b0; ReqValid = 1'b0;
        seen = 1'b0;
        repeat (LATENCY + 3) begin
            if (RspValid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_idle_no_rsp", 32'(seen), 32'd0);

        fetch(32'h8, 0, 1);
        fetch(32'h0, 0, 0);
        fetch(32'hC, 0, 2);

        // Reset while waiting.
        ReqValid = 1'b1; ReqAddr = 32'h4;
        @(negedge clk);
        ReqValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rstw_valid", 32'(RspValid), 32'd0);
        check("rstw_ready", 32'(ReqReady), 32'd1);
        check("rstw_addr", RspAddr, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        seen = 1'b0;
        @(negedge clk);
        repeat (LATENCY + 3) begin
            if (RspValid) seen = 1'b1;
            @(negedge clk);
        end
        check("rstw_no_rsp", 32'(seen), 32'd0);
        fetch(32'h4, 0, 0);

        // Reset while responding.
        ReqValid = 1'b1; ReqAddr = 32'h4;
        @(negedge clk);
        ReqValid = 1'b0;
        repeat (LATENCY - 1) @(negedge clk);
        check("rstr_pre_valid", 32'(RspValid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rstr_valid", 32'(RspValid), 32'd0);
        check("rstr_instr", RspInstr, 32'd0);
        #2 reset = 1'b1;
        @(negedge clk);

        // Write on the same edge that enters RESP.
        ReqValid = 1'b1; ReqAddr = 32'h4;
        if (LATENCY > 1) begin
            @(negedge clk);
            ReqValid = 1'b0;
            repeat (LATENCY - 2) @(negedge clk);
        end
        WrEn = 1'b1; WrAddr = 32'h4; WrData = 32'h12345678;
        @(negedge clk);
        WrEn = 1'b0; ReqValid = 1'b0;
        check("race_valid", 32'(RspValid), 32'd1);
        check("race_instr", RspInstr, 32'hDEADBEEF);
        model_mem[1] = 32'h12345678;
        RspReady = 1'b1;
        @(negedge clk);
        RspReady = 1'b0;
        fetch(32'h4, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                a = (r == 0) ? 32'($urandom_range(0, DEPTH + 8)) * 4 : $urandom;
                write_word(a, $urandom);
            end else begin
                r = $urandom_range(0, 19);
                if (r < 14)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
                else if (r < 17) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                else             a = 32'($urandom_range(DEPTH, DEPTH + 100)) * 4;
                r = $urandom_range(0, 9);
                fetch(a, $urandom_range(0, 4), (r == 0) ? 1 : (r == 1) ? 2 : 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request acceptance to RspValid; legal range is 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ReqValid  input  1  fetch request present.
REQ-006 SHALL have port ReqReady  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port ReqAddr  input  32  byte address of the fetch.
REQ-008 SHALL have port Flush  input  1  taken branch (PCSrc); discard any in-flight fetch.
REQ-009 SHALL have port RspValid  output  1  response present.
REQ-010 SHALL have port RspReady  input  1  requester consumes the response.
REQ-011 SHALL have port RspInstr  output  32  fetched instruction word.
REQ-012 SHALL have port RspAddr  output  32  byte address of the response.
REQ-013 SHALL have port RspErr  output  1  request was misaligned or out of range.
REQ-014 SHALL have port WrEn  input  1  program-load write strobe.
REQ-015 SHALL have port WrAddr  input  32  program-load byte address.
REQ-016 SHALL have port WrData  input  32  program-load data.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-018 SHALL drive ReqReady = 1 only in IDLE with Flush = 0.
REQ-019 SHALL accept a request on an edge where ReqValid & ReqReady, capturing ReqAddr into RspAddr.
REQ-020 On accept, SHALL go to RESP if LATENCY = 1; otherwise SHALL go to WAIT with a down-counter loaded with LATENCY-2.
REQ-021 In WAIT, SHALL decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-022 SHALL capture RspInstr and RspErr on the edge entering RESP, using memory contents before that edge (read-before-write).
REQ-023 In RESP, SHALL hold RspValid = 1 and hold RspInstr/RspAddr/RspErr stable until an edge where RspReady = 1, then go to IDLE.
REQ-024 SHALL NOT accept back-to-back requests; at most one request is in flight, and ReqReady is 0 in WAIT and RESP.
REQ-025 SHALL set RspErr = 1 and RspInstr = 32'h0 when ReqAddr[1:0] != 0 or ReqAddr[31:2] >= DEPTH; LATENCY is unchanged for error responses.
REQ-026 Flush = 1 in WAIT or RESP SHALL force IDLE on the next edge, with no response produced; Flush takes priority over RspReady.
REQ-027 Flush = 1 in IDLE SHALL block acceptance for that cycle.
REQ-028 WrEn = 1 SHALL write WrData to word WrAddr[31:2] on the edge, in any state.
REQ-029 SHALL ignore writes with a misaligned or out-of-range WrAddr.
REQ-030 RspValid SHALL be 0 in IDLE and WAIT.

Reset
REQ-031 reset = 0 SHALL immediately force IDLE, counter = 0, RspValid = 0, RspErr = 0, RspInstr = 0 and RspAddr = 0, regardless of clk.
REQ-032 Reset asserted mid-fetch SHALL drop the in-flight request without producing a response.
REQ-033 Memory contents SHALL NOT be altered by reset.
REQ-034 After reset deassertion, ReqReady SHALL be 1 in the first cycle with Flush = 0.

Verification
REQ-035 Basic fetch: load word 1 = 32'hDEADBEEF; request 32'h4 at LATENCY 2 -> RspValid at the 2nd edge after accept, RspInstr = DEADBEEF, RspAddr = 4, RspErr = 0.
REQ-036 Backpressure: hold RspReady = 0 for 5 cycles -> RspValid and data stable throughout; ReqReady = 1 one cycle after the RspReady edge.
REQ-037 Errors: request 32'h6, then request 32'h100 with DEPTH 64 -> each gives RspErr = 1, RspInstr = 0, latency 2.
REQ-038 Flush: Flush = 1 in WAIT -> no RspValid ever for that request; next request 32'h0 is accepted and served normally.
REQ-039 Write/read race: write word 1 = 32'h12345678 on the same edge that enters RESP for address 4 -> RspInstr = DEADBEEF; the next fetch of 4 returns 12345678.
REQ-040 Reset in WAIT: reset = 0 asynchronously between edges -> RspValid = 0 and state IDLE immediately; memory still holds DEADBEEF.
